eth_tx_mux_arb: RTL and testbench

- Parametrised GMII transmit arbiter; the multi-channel successor to the two-source ARP/UDP transmit mux.
- Sits between NUM_CH packet sources (ARP, UDP, ICMP, ...) and the single gmii_tx_en/gmii_txd path into the GMII-to-RGMII converter.
- Grants one whole frame at a time, using fixed-priority or round-robin arbitration.
- Enforces a programmable inter-frame gap and a runaway-frame watchdog.

---
 rtl/eth_tx_mux_arb.sv | 191 +++++++++++++++++++
 tb/tb_eth_tx_mux_arb.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_mux_arb.sv
`default_nettype none
// ============================================================================
//  Module   : eth_tx_mux_arb
//  Purpose  : GMII transmit arbiter granting whole frames from NUM_CH sources,
//             with fixed-priority or round-robin selection, a forced
//             inter-frame gap, a start timeout and a runaway-frame watchdog.
//  Revision : 1.0  initial release
// ============================================================================
module eth_tx_mux_arb #(
    parameter int NUM_CH        = 2,
    parameter int ARB_MODE      = 0,
    parameter int IFG_CYCLES    = 12,
    parameter int START_TIMEOUT = 64,
    parameter int MAX_FRAME_CYC = 1530,
    localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_CH-1:0]     ch_req,
    output logic [NUM_CH-1:0]     ch_grant,
    input  logic [NUM_CH-1:0]     ch_tx_en,
    input  logic [NUM_CH*8-1:0]   ch_txd,
    output logic                  gmii_tx_en,
    output logic [7:0]            gmii_txd,
    output logic [CH_W-1:0]       cur_ch,
    output logic                  busy,
    output logic                  err_timeout,
    output logic                  err_overlong
);

    localparam int c_MAX_AB  = (START_TIMEOUT > MAX_FRAME_CYC) ? START_TIMEOUT : MAX_FRAME_CYC;
    localparam int c_CNT_MAX = (c_MAX_AB > IFG_CYCLES) ? c_MAX_AB : IFG_CYCLES;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_TO_LAST   = c_CNT_W'(START_TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_FRAME_MAX = c_CNT_W'(MAX_FRAME_CYC);
    localparam logic [c_CNT_W-1:0] c_IFG_LAST  = c_CNT_W'(IFG_CYCLES - 1);
    localparam logic [CH_W-1:0]    c_LAST_CH   = CH_W'(NUM_CH - 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_WAIT  = 2'd1;
    localparam logic [1:0] c_ST_SEND  = 2'd2;
    localparam logic [1:0] c_ST_IFG   = 2'd3;

    logic [1:0]          r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [NUM_CH-1:0]   r_grant;
    logic [CH_W-1:0]     r_cur_ch;
    logic                r_gmii_tx_en;
    logic [7:0]          r_gmii_txd;
    logic                r_err_timeout;
    logic                r_err_overlong;

    logic [CH_W-1:0]     w_winner;
    logic [NUM_CH-1:0]   w_winner_oh;
    logic                w_sel_en;
    logic [7:0]          w_sel_txd;

    generate
        if (ARB_MODE == 0) begin : g_fixed
            always_comb begin
                w_winner = '0;
                for (int i = NUM_CH - 1; i >= 0; i--) begin
                    if (ch_req[i]) w_winner = i[CH_W-1:0];
                end
            end
        end else begin : g_rr
            logic [CH_W-1:0] r_ptr;
            logic [CH_W-1:0] w_hi;
            logic [CH_W-1:0] w_lo;
            logic            w_hi_found;

            // First requester at or above the pointer, else wrap to the lowest one.
            always_comb begin
                w_hi       = '0;
                w_lo       = '0;
                w_hi_found = 1'b0;
                for (int i = NUM_CH - 1; i >= 0; i--) begin
                    if (ch_req[i]) begin
                        w_lo = i[CH_W-1:0];
                        if (i[CH_W-1:0] >= r_ptr) begin
                            w_hi       = i[CH_W-1:0];
                            w_hi_found = 1'b1;
                        end
                    end
                end
                w_winner = w_hi_found ? w_hi : w_lo;
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_ptr <= '0;
                end else if (r_state == c_ST_IDLE && |ch_req) begin
                    r_ptr <= (w_winner == c_LAST_CH) ? '0 : w_winner + CH_W'(1);
                end
            end
        end
    endgenerate

    always_comb begin
        w_sel_en    = 1'b0;
        w_sel_txd   = '0;
        w_winner_oh = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_winner_oh[i] = (w_winner == i[CH_W-1:0]);
            if (r_cur_ch == i[CH_W-1:0]) begin
                w_sel_en  = ch_tx_en[i];
                w_sel_txd = ch_txd[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= c_ST_IDLE;
            r_cnt          <= '0;
            r_grant        <= '0;
            r_cur_ch       <= '0;
            r_gmii_tx_en   <= 1'b0;
            r_gmii_txd     <= '0;
            r_err_timeout  <= 1'b0;
            r_err_overlong <= 1'b0;
        end else begin
            r_err_timeout  <= 1'b0;
            r_err_overlong <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    r_gmii_tx_en <= 1'b0;
                    r_gmii_txd   <= '0;
                    r_cnt        <= '0;
                    if (|ch_req) begin
                        r_grant  <= w_winner_oh;
                        r_cur_ch <= w_winner;
                        r_state  <= c_ST_WAIT;
                    end
                end
                c_ST_WAIT: begin
                    // The enabling byte itself goes out, so the frame loses nothing.
                    if (w_sel_en) begin
                        r_gmii_tx_en <= 1'b1;
                        r_gmii_txd   <= w_sel_txd;
                        r_cnt        <= c_CNT_W'(1);
                        r_state      <= c_ST_SEND;
                    end else if (r_cnt == c_TO_LAST) begin
                        r_grant       <= '0;
                        r_err_timeout <= 1'b1;
                        r_cnt         <= '0;
                        r_state       <= c_ST_IFG;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                c_ST_SEND: begin
                    // r_cnt holds the number of bytes already sent in this frame.
                    if (w_sel_en && r_cnt < c_FRAME_MAX) begin
                        r_gmii_tx_en <= 1'b1;
                        r_gmii_txd   <= w_sel_txd;
                        r_cnt        <= r_cnt + c_CNT_W'(1);
                    end else begin
                        r_gmii_tx_en   <= 1'b0;
                        r_gmii_txd     <= '0;
                        r_grant        <= '0;
                        r_err_overlong <= w_sel_en;
                        r_cnt          <= '0;
                        r_state        <= c_ST_IFG;
                    end
                end
                default: begin
                    r_gmii_tx_en <= 1'b0;
                    r_gmii_txd   <= '0;
                    if (r_cnt == c_IFG_LAST) begin
                        r_cnt   <= '0;
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
            endcase
        end
    end

    assign ch_grant     = r_grant;
    assign gmii_tx_en   = r_gmii_tx_en;
    assign gmii_txd     = r_gmii_txd;
    assign cur_ch       = r_cur_ch;
    assign busy         = (r_state != c_ST_IDLE);
    assign err_timeout  = r_err_timeout;
    assign err_overlong = r_err_overlong;

endmodule
`default_nettype wire

// File: tb/tb_eth_tx_mux_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_eth_tx_mux_arb
//  Purpose  : Directed self-checking bench: a 2-channel fixed-priority
//             instance and a 4-channel round-robin instance.
//  Revision : 1.0  initial release
// ============================================================================
module tb_eth_tx_mux_arb;

    logic        clk = 1'b0;
    logic        rst;

    logic [1:0]  req_f, grant_f, txen_f;
    logic [15:0] txd_f;
    logic        gtxen_f, busy_f, eto_f, eov_f;
    logic [7:0]  gtxd_f;
    logic [0:0]  cur_f;

    logic [3:0]  req_r, grant_r, txen_r;
    logic [31:0] txd_r;
    logic        gtxen_r, busy_r, eto_r, eov_r;
    logic [7:0]  gtxd_r;
    logic [1:0]  cur_r;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    eth_tx_mux_arb #(.NUM_CH(2), .ARB_MODE(0)) dut_fix (
        .clk(clk), .rst(rst), .ch_req(req_f), .ch_grant(grant_f),
        .ch_tx_en(txen_f), .ch_txd(txd_f), .gmii_tx_en(gtxen_f), .gmii_txd(gtxd_f),
        .cur_ch(cur_f), .busy(busy_f), .err_timeout(eto_f), .err_overlong(eov_f)
    );

    eth_tx_mux_arb #(.NUM_CH(4), .ARB_MODE(1)) dut_rr (
        .clk(clk), .rst(rst), .ch_req(req_r), .ch_grant(grant_r),
        .ch_tx_en(txen_r), .ch_txd(txd_r), .gmii_tx_en(gtxen_r), .gmii_txd(gtxd_r),
        .cur_ch(cur_r), .busy(busy_r), .err_timeout(eto_r), .err_overlong(eov_r)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Outputs are sampled 1 time unit after the edge; inputs set then apply at the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n, lowcnt, n_hi, n_eov, eov_k, n_bad, n_leak;
        logic [7:0] b;

        rst = 1'b1;
        req_f = '0; txen_f = '0; txd_f = '0;
        req_r = '0; txen_r = '0; txd_r = '0;
        repeat (3) step();
        check("rst_outs_fix", 32'({grant_f, gtxen_f, gtxd_f, cur_f, busy_f, eto_f, eov_f}), 32'd0);
        check("rst_outs_rr",  32'({grant_r, gtxen_r, gtxd_r, cur_r, busy_r, eto_r, eov_r}), 32'd0);
        rst = 1'b0;
        step();

        // ---------------- round robin, all requests held ----------------
        req_r  = 4'hF;
        lowcnt = 0;
        for (int f = 0; f < 5; f++) begin
            n = 0;
            while (grant_r == 4'd0 && n < 50) begin
                step();
                n++;
                if (!gtxen_r) lowcnt++;
            end
            check("rr_grant", 32'(grant_r), 32'(4'd1 << (f % 4)));
            check("rr_cur", 32'(cur_r), 32'(f % 4));
            if (f == 4) req_r = 4'h0;
            for (int k = 0; k < 10; k++) begin
                b = 8'((f % 4) * 16 + k);
                txen_r = 4'(4'd1 << (f % 4));
                txd_r  = '0;
                txd_r[8*(f%4) +: 8] = b;
                step();
                if (k == 0 && f > 0) check("rr_gap_ge12", 32'(lowcnt >= 12), 32'd1);
                check("rr_byte", 32'({gtxen_r, gtxd_r}), 32'({1'b1, b}));
            end
            txen_r = '0;
            txd_r  = '0;
            step();
            lowcnt = 1;
        end

        // ---------------- fixed priority, both request together ----------------
        req_f = 2'b11;
        step();
        check("t1_grant0", 32'({grant_f, cur_f, busy_f}), 32'({2'b01, 1'b0, 1'b1}));
        req_f = 2'b10;
        for (int k = 0; k < 60; k++) begin
            b = 8'(8'h10 + k);
            txen_f = 2'b11;                     // ch1 tries to leak 8'hAA
            txd_f  = {8'hAA, b};
            step();
            check("t1_ch0_byte", 32'({gtxen_f, gtxd_f}), 32'({1'b1, b}));
        end
        txen_f = '0;
        txd_f  = '0;
        step();
        check("t1_end", 32'({gtxen_f, grant_f, busy_f}), 32'({1'b0, 2'b00, 1'b1}));
        n = 1;
        n_leak = 0;
        while (grant_f == 2'd0 && n < 200) begin
            step();
            n++;
            if (gtxen_f || gtxd_f != 8'h00) n_leak++;
        end
        check("t1_ifg_to_grant", 32'(n), 32'd14);
        check("t1_gap_quiet", 32'(n_leak), 32'd0);
        check("t1_grant1", 32'({grant_f, cur_f}), 32'({2'b10, 1'b1}));
        req_f = 2'b00;
        for (int k = 0; k < 42; k++) begin
            b = 8'(8'h80 + k);
            txen_f = 2'b10;
            txd_f  = {b, 8'h00};
            step();
            check("t1_ch1_byte", 32'({gtxen_f, gtxd_f}), 32'({1'b1, b}));
        end
        txen_f = '0;
        txd_f  = '0;
        step();
        repeat (11) step();
        check("t1_busy_last_ifg", 32'(busy_f), 32'd1);
        step();
        check("t1_idle_after_ifg", 32'(busy_f), 32'd0);

        // ---------------- start timeout, then overlong frame ----------------
        req_f = 2'b10;
        step();
        check("t3_grant1", 32'(grant_f), 32'(2'b10));
        req_f = 2'b01;
        n = 0;
        while (!eto_f && n < 200) begin
            step();
            n++;
        end
        check("t3_timeout_cycles", 32'(n), 32'd64);
        check("t3_grant_drop", 32'({grant_f, gtxen_f, busy_f}), 32'({2'b00, 1'b0, 1'b1}));
        step();
        check("t3_eto_pulse", 32'(eto_f), 32'd0);
        n = 1;
        while (grant_f == 2'd0 && n < 200) begin
            step();
            n++;
        end
        check("t3_ifg_to_grant0", 32'(n), 32'd13);
        check("t3_grant0", 32'(grant_f), 32'(2'b01));
        req_f = 2'b00;

        n_hi = 0; n_eov = 0; eov_k = -1; n_bad = 0; n_leak = 0;
        for (int k = 0; k < 2000; k++) begin
            b = 8'(k + 1);
            txen_f = 2'b01;
            txd_f  = {8'h00, b};
            step();
            if (gtxen_f) begin
                n_hi++;
                if (gtxd_f != b || k >= 1530) n_bad++;
            end else if (gtxd_f != 8'h00) begin
                n_leak++;
            end
            if (eov_f) begin
                n_eov++;
                eov_k = k;
                check("t4_grant_drop", 32'(grant_f), 32'd0);
            end
        end
        txen_f = '0;
        txd_f  = '0;
        check("t4_high_cycles", 32'(n_hi), 32'd1530);
        check("t4_eov_count", 32'(n_eov), 32'd1);
        check("t4_eov_when", 32'(eov_k), 32'd1530);
        check("t4_bytes", 32'(n_bad), 32'd0);
        check("t4_no_leak", 32'(n_leak), 32'd0);
        repeat (3) step();

        // ---------------- reset mid-frame ----------------
        req_f = 2'b01;
        step();
        check("t6_grant0", 32'(grant_f), 32'(2'b01));
        req_f = 2'b00;
        for (int k = 0; k < 20; k++) begin
            b = 8'(8'h50 + k);
            txen_f = 2'b01;
            txd_f  = {8'h00, b};
            step();
            check("t6_byte", 32'({gtxen_f, gtxd_f}), 32'({1'b1, b}));
        end
        txd_f = {8'h00, 8'h64};
        rst   = 1'b1;
        step();
        check("t6_after_rst", 32'({gtxen_f, grant_f, busy_f}), 32'd0);
        rst    = 1'b0;
        txen_f = '0;
        txd_f  = '0;
        req_f  = 2'b10;
        step();
        check("t6_no_ifg_grant", 32'({grant_f, cur_f, busy_f}), 32'({2'b10, 1'b1, 1'b1}));
        req_f = 2'b00;
        repeat (2) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
